// File: rtl/machine_timer_if.sv
// machine_timer_if: data-bus peripheral port between core and machine timer
interface machine_timer_if;
  logic valid;
  logic we;
  logic [4:0] addr;
  logic [31:0] wdata;
  logic ready;
  logic rvalid;
  logic [31:0] rdata;
  logic err;
  modport master (output valid, we, addr, wdata, input ready, rvalid, rdata, err);
  modport slave (input valid, we, addr, wdata, output ready, rvalid, rdata, err);
endinterface

// File: rtl/machine_timer.sv
// machine_timer: RISC-V mtime/mtimecmp timer with prescaler and coherent 64-bit reads
module machine_timer #(
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [7:0] PRESCALE_RESET = 8'd0
) (
  input logic clk,
  input logic reset,
  machine_timer_if.slave bus,
  output logic timer_irq
);
  logic [63:0] mtime, mtimecmp, mtime_n, mtimecmp_n;
  logic [31:0] snap, snap_n, rd;
  logic [7:0] div, div_n, cnt, cnt_n;
  logic en, en_n, tick, wr, re, ctrl_wr;
  logic [2:0] a;
  assign bus.ready = 1'b1;
  assign a = bus.addr[4:2];
  assign wr = bus.valid & bus.we;
  assign re = bus.valid & ~bus.we;
  assign ctrl_wr = wr & (a == 3'd4);
  assign tick = en & (cnt == div);
  // next-state of every timer register; a software write to an mtime half wins over the tick
  always_comb begin
    mtime_n = (wr && a == 3'd0) ? {mtime[63:32], bus.wdata}
            : (wr && a == 3'd1) ? {bus.wdata, mtime[31:0]}
            : mtime + {63'd0, tick};
    mtimecmp_n = (wr && a == 3'd2) ? {mtimecmp[63:32], bus.wdata}
               : (wr && a == 3'd3) ? {bus.wdata, mtimecmp[31:0]}
               : mtimecmp;
    en_n = ctrl_wr ? bus.wdata[0] : en;
    div_n = ctrl_wr ? bus.wdata[15:8] : div;
    cnt_n = (ctrl_wr || tick) ? 8'd0 : en ? cnt + 8'd1 : cnt;
    snap_n = (re && a == 3'd0) ? mtime[63:32] : (wr && a == 3'd1) ? bus.wdata : snap;
    rd = !re ? 32'd0
       : a == 3'd0 ? mtime[31:0]
       : a == 3'd1 ? snap
       : a == 3'd2 ? mtimecmp[31:0]
       : a == 3'd3 ? mtimecmp[63:32]
       : a == 3'd4 ? {16'd0, div, 7'd0, en}
       : 32'd0;
  end
  // register state, the one-cycle bus response and the interrupt compare on next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= 64'd0;
      mtimecmp <= MTIMECMP_RESET;
      en <= 1'b1;
      div <= PRESCALE_RESET;
      cnt <= 8'd0;
      snap <= 32'd0;
      bus.rvalid <= 1'b0;
      bus.err <= 1'b0;
      bus.rdata <= 32'd0;
      timer_irq <= 1'b0;
    end else begin
      mtime <= mtime_n;
      mtimecmp <= mtimecmp_n;
      en <= en_n;
      div <= div_n;
      cnt <= cnt_n;
      snap <= snap_n;
      bus.rvalid <= bus.valid;
      bus.err <= bus.valid & (a > 3'd4);
      bus.rdata <= rd;
      timer_irq <= en_n & (mtime_n >= mtimecmp_n);
    end
  end
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed and random bus traffic checked against a behavioural timer model
module tb_machine_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic timer_irq;
  machine_timer_if bus();
  machine_timer dut (.clk(clk), .reset(reset), .bus(bus.slave), .timer_irq(timer_irq));
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;
  longint unsigned m_time, m_cmp;
  bit m_en;
  bit [7:0] m_div;
  int m_cnt;
  bit [31:0] m_snap;
  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic model_reset();
    m_time = 0;
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en = 1'b1;
    m_div = 8'd0;
    m_cnt = 0;
    m_snap = 0;
  endtask
  task automatic step(input bit v, input bit we, input bit [4:0] a, input bit [31:0] d, input bit rst = 1'b0);
    bit [31:0] rd;
    bit [2:0] w;
    bit tick, old_en;
    longint unsigned nt;
    reset = rst;
    bus.valid = v;
    bus.we = we;
    bus.addr = a;
    bus.wdata = d;
    w = a[4:2];
    rd = 0;
    if (v && !we)
      case (w)
        3'd0: rd = m_time[31:0];
        3'd1: rd = m_snap;
        3'd2: rd = m_cmp[31:0];
        3'd3: rd = m_cmp[63:32];
        3'd4: rd = {16'd0, m_div, 7'd0, m_en};
        default: rd = 0;
      endcase
    if (rst) model_reset();
    else begin
      tick = m_en && (m_cnt == int'(m_div));
      old_en = m_en;
      if (v && !we && w == 3'd0) m_snap = m_time[63:32];
      nt = m_time + (tick ? 64'd1 : 64'd0);
      if (v && we)
        case (w)
          3'd0: nt = {m_time[63:32], d};
          3'd1: begin nt = {d, m_time[31:0]}; m_snap = d; end
          3'd2: m_cmp[31:0] = d;
          3'd3: m_cmp[63:32] = d;
          3'd4: begin m_en = d[0]; m_div = d[15:8]; end
          default: ;
        endcase
      if (v && we && w == 3'd4) m_cnt = 0;
      else if (tick) m_cnt = 0;
      else if (old_en) m_cnt++;
      m_time = nt;
    end
    @(posedge clk);
    #1;
    check("rvalid", bus.rvalid, v && !rst);
    check("err", bus.err, v && !rst && w > 3'd4);
    if (v && !rst) check("rdata", bus.rdata, rd);
    check("irq", timer_irq, !rst && m_en && m_time >= m_cmp);
  endtask
  task automatic wr(input bit [4:0] a, input bit [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask
  task automatic rd(input bit [4:0] a);
    step(1'b1, 1'b0, a, 32'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0);
  endtask
  initial begin
    bit [31:0] v0, delta, d;
    bit [4:0] a;
    bit [2:0] w;
    bit v, we;
    int n;
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    check("ready", bus.ready, 1);
    check("reset_rdata", bus.rdata, 0);
    // mtimecmp = 10 with hi parked at all-ones during the update
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h08, 32'd10);
    wr(5'h0C, 32'd0);
    n = 0;
    while (!timer_irq && n < 30) begin idle(1); n++; end
    check("irq_rise", timer_irq, 1);
    rd(5'h00);
    check("irq_at_lo", bus.rdata, 32'hA);
    idle(5);
    check("irq_held", timer_irq, 1);
    // div=3: +10 over 40 cycles, then frozen with en=0
    wr(5'h10, 32'h301);
    rd(5'h00);
    v0 = bus.rdata;
    idle(39);
    rd(5'h00);
    delta = bus.rdata - v0;
    check("div3_delta", delta, 10);
    wr(5'h10, 32'h300);
    rd(5'h00);
    v0 = bus.rdata;
    idle(19);
    rd(5'h00);
    delta = bus.rdata - v0;
    check("frozen_delta", delta, 0);
    // lo->hi carry
    wr(5'h10, 32'h1);
    wr(5'h04, 32'd0);
    wr(5'h00, 32'hFFFF_FFFF);
    rd(5'h00);
    check("carry_lo_before", bus.rdata, 32'hFFFF_FFFF);
    rd(5'h00);
    check("carry_lo_after", bus.rdata, 0);
    rd(5'h04);
    check("carry_hi", bus.rdata, 1);
    // hi snapshot survives a later carry
    wr(5'h00, 32'hFFFF_FFF0);
    rd(5'h00);
    idle(20);
    rd(5'h04);
    check("snapshot_hi", bus.rdata, 1);
    rd(5'h00);
    rd(5'h04);
    check("live_hi", bus.rdata, 2);
    // write beats tick
    wr(5'h00, 32'h100);
    rd(5'h00);
    check("write_over_tick", bus.rdata, 32'h100);
    // 64-bit wrap drops the interrupt
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'd5);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h00, 32'hFFFF_FFFF);
    check("irq_before_wrap", timer_irq, 1);
    idle(2);
    check("irq_after_wrap", timer_irq, 0);
    // unmapped
    rd(5'h18);
    check("unmapped_rdata", bus.rdata, 0);
    check("unmapped_err", bus.err, 1);
    // back-to-back from reset
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    rd(5'h08);
    check("b2b_cmp_lo", bus.rdata, 32'hFFFF_FFFF);
    rd(5'h0C);
    check("b2b_cmp_hi", bus.rdata, 32'hFFFF_FFFF);
    rd(5'h10);
    check("b2b_ctrl", bus.rdata, 1);
    check("b2b_rvalid", bus.rvalid, 1);
    // reset on an accepted request
    step(1'b1, 1'b0, 5'h00, 32'd0, 1'b1);
    check("reset_drop", bus.rvalid, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      v = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 2) == 0;
      w = 3'($urandom_range(0, 7) > 5 ? $urandom_range(5, 7) : $urandom_range(0, 4));
      a = {w, 2'($urandom_range(0, 3))};
      d = $urandom;
      case (w)
        3'd0: d = $urandom_range(0, 1) ? d : 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        3'd1: d = m_time[63:32] + 32'($urandom_range(0, 1));
        3'd2: d = m_time[31:0] + 32'($urandom_range(0, 40));
        3'd3: d = m_time[63:32] + 32'($urandom_range(0, 1));
        3'd4: d = {16'd0, 8'($urandom_range(0, 3)), 7'd0, 1'($urandom_range(0, 7) != 0)};
        default: ;
      endcase
      step(v, we, a, d, $urandom_range(0, 499) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
